// File: rtl/mux_pkg.sv
// Shared types and the round-robin pick helper for the 8:1 gathering mux.
// Used by rr_arbiter_8 and mux_8_1_rr.
package mux_pkg;

    localparam int unsigned NCH  = 8;
    localparam int unsigned SELW = 3;

    typedef logic [SELW-1:0] sel_t;

    typedef struct packed {
        logic found;
        sel_t sel;
    } pick_t;

    // First requesting lane at or after ptr, wrapping 7 -> 0.
    function automatic pick_t rr_pick(input logic [NCH-1:0] req, input sel_t ptr);
        pick_t res;
        sel_t  idx;
        res.found = 1'b0;
        res.sel   = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = ptr + sel_t'(i);
            if (!res.found && req[idx]) begin
                res.found = 1'b1;
                res.sel   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational 8-way round-robin arbiter; grants only while load_i is high.
module rr_arbiter_8
    import mux_pkg::*;
(
    input  logic [NCH-1:0] req_i,
    input  sel_t           ptr_i,
    input  logic           load_i,
    output logic [NCH-1:0] grant_oh_o,
    output sel_t           grant_idx_o,
    output logic           grant_vld_o
);

    pick_t pick;

    always_comb begin
        pick        = rr_pick(req_i, ptr_i);
        grant_idx_o = pick.sel;
        grant_vld_o = load_i & pick.found;
        grant_oh_o  = '0;
        if (grant_vld_o) begin
            grant_oh_o[pick.sel] = 1'b1;
        end
    end

endmodule

// File: rtl/mux_8_1_rr.sv
// 8:1 valid/ready gathering mux with round-robin arbitration and a registered, lane-tagged output.
// Optional MUX_FORCE_SEL_EN adds force_en_i/force_sel_i to restrict eligibility to one lane.
module mux_8_1_rr
    import mux_pkg::*;
#(
    parameter int unsigned DW = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    in_valid_i,
    input  logic [NCH*DW-1:0] in_data_i,
    output logic [NCH-1:0]    in_ready_o,
    output logic              out_valid_o,
    output logic [DW-1:0]     out_data_o,
    output sel_t              out_sel_o,
`ifdef MUX_FORCE_SEL_EN
    input  logic              force_en_i,
    input  sel_t              force_sel_i,
`endif
    input  logic              out_ready_i
);

    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    sel_t           out_sel_q, out_sel_d;
    sel_t           rr_ptr_q, rr_ptr_d;

    logic           load;
    logic [NCH-1:0] req;
    logic           ptr_upd;
    logic [NCH-1:0] grant_oh;
    sel_t           grant_idx;
    logic           grant_vld;

    // Reset folds into load so no lane sees ready while rst_i is high.
    assign load = (!out_valid_q || out_ready_i) && !rst_i;

`ifdef MUX_FORCE_SEL_EN
    always_comb begin
        req = in_valid_i;
        if (force_en_i) begin
            req = in_valid_i & ({{(NCH-1){1'b0}}, 1'b1} << force_sel_i);
        end
    end
    assign ptr_upd = !force_en_i;
`else
    assign req     = in_valid_i;
    assign ptr_upd = 1'b1;
`endif

    rr_arbiter_8 u_arb (
        .req_i       (req),
        .ptr_i       (rr_ptr_q),
        .load_i      (load),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (grant_vld) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data_i[grant_idx*DW +: DW];
                out_sel_d   = grant_idx;
                if (ptr_upd) begin
                    rr_ptr_d = grant_idx + sel_t'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign in_ready_o  = grant_oh;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule
